zx_ps2_matrix: RTL and testbench

- Receives PS/2 set-2 scan codes from the keyboard and keeps a 40-key ZX Spectrum matrix (8 half-rows x 5 keys) up to date.
- The CPU reads the matrix through port xFE: the top level drives the high address byte onto zx_kb_scan, and the block returns the 5 active-low key bits.
- Sits directly upstream of the system top's port xFE read mux, on the 14 MHz pixel clock.

---
 rtl/zx_ps2_matrix.sv | 274 +++++++++++++++++++++++++++
 tb/tb_zx_ps2_matrix.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/zx_ps2_matrix.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : zx_ps2_matrix                                                |
// | Description : PS/2 set-2 keyboard receiver that maintains a 40-key ZX      |
// |               Spectrum matrix (8 half-rows x 5 keys) read through xFE.     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk        in   14 MHz system clock                                      |
// |   reset      in   asynchronous active-low reset                            |
// |   ps2_clk    in   raw PS/2 clock (asynchronous)                            |
// |   ps2_data   in   raw PS/2 data  (asynchronous)                            |
// |   zx_kb_scan in   CPU A[15:8], a 0 bit selects that half-row               |
// |   zx_kb_out  out  active-low key bits of the selected half-row(s)          |
// |   k_joy      out  Kempston state: 0 right, 1 left, 2 down, 3 up, 4 fire   |
// |   res_k      out  one-clk pulse on Ctrl+Alt+Del                            |
// |   frame_err  out  one-clk pulse on a rejected frame                        |
// | Build option                                                               |
// |   ZX_KEMPSTON_EN : arrows/RAlt drive k_joy instead of CS+5..8 composites   |
// +----------------------------------------------------------------------------+
module zx_ps2_matrix #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 28000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic [7:0] zx_kb_scan,
    output logic [4:0] zx_kb_out,
    output logic [4:0] k_joy,
    output logic       res_k,
    output logic       frame_err
);
    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FW-1:0] C_FLT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] C_TO_LAST  = TW'(TIMEOUT_CYC - 1);

    // Key sources: 0..39 are matrix positions (row*5 + bit), the rest are
    // sources that feed composite keys or modifier tracking.
    localparam int SRC_LCTRL = 40;
    localparam int SRC_BKSP  = 41;
    localparam int SRC_RIGHT = 42;
    localparam int SRC_LEFT  = 43;
    localparam int SRC_DOWN  = 44;
    localparam int SRC_UP    = 45;
    localparam int SRC_RALT  = 46;
    localparam int SRC_LALT  = 47;
    localparam int SRC_RCTRL = 48;
    localparam int SRC_DEL   = 49;
    localparam int NSRC      = 50;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    // ------------------------------------------------------------------ sync
    logic [1:0]    clk_sync_q, dat_sync_q;
    logic          flt_q;
    logic [FW-1:0] flt_cnt_q;
    logic          w_differ, w_fall, w_bit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_data};
        end
    end

    // The filtered clock flips only after FILTER_LEN consecutive samples
    // disagree with it; the flip cycle of a 1->0 change is the sample point.
    assign w_differ = clk_sync_q[1] ^ flt_q;
    assign w_fall   = w_differ && (flt_cnt_q == C_FLT_LAST) && flt_q;
    assign w_bit    = dat_sync_q[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flt_q     <= 1'b1;
            flt_cnt_q <= '0;
        end else if (!w_differ) begin
            flt_cnt_q <= '0;
        end else if (flt_cnt_q == C_FLT_LAST) begin
            flt_q     <= ~flt_q;
            flt_cnt_q <= '0;
        end else begin
            flt_cnt_q <= flt_cnt_q + 1'b1;
        end
    end

    // -------------------------------------------------------------- receiver
    state_t        state_q, state_d;
    logic [7:0]    shift_q;
    logic [2:0]    bitcnt_q;
    logic          par_q;
    logic [TW-1:0] to_cnt_q;
    logic          w_timeout, w_stop_edge, w_good, w_bad;

    assign w_timeout   = (state_q != S_IDLE) && !w_fall && (to_cnt_q == C_TO_LAST);
    assign w_stop_edge = w_fall && (state_q == S_STOP);
    assign w_good      = w_stop_edge && w_bit && (^{shift_q, par_q});
    assign w_bad       = w_stop_edge && !(w_bit && (^{shift_q, par_q}));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (w_timeout) begin
            state_d = S_IDLE;
        end else if (w_fall) begin
            case (state_q)
                S_IDLE:   if (!w_bit) state_d = S_DATA;
                S_DATA:   if (bitcnt_q == 3'd7) state_d = S_PARITY;
                S_PARITY: state_d = S_STOP;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q  <= '0;
            bitcnt_q <= '0;
            par_q    <= 1'b0;
            to_cnt_q <= '0;
        end else begin
            if (state_q == S_IDLE || w_fall) to_cnt_q <= '0;
            else if (to_cnt_q != C_TO_LAST)  to_cnt_q <= to_cnt_q + 1'b1;
            if (w_fall) begin
                case (state_q)
                    S_IDLE:   bitcnt_q <= '0;
                    S_DATA: begin
                        shift_q  <= {w_bit, shift_q[7:1]};
                        bitcnt_q <= bitcnt_q + 3'd1;
                    end
                    S_PARITY: par_q <= w_bit;
                    default:  ;
                endcase
            end
        end
    end

    // --------------------------------------------------------------- decoder
    // Returns {valid, source index} for a scan code.
    function automatic logic [6:0] map_code(input logic ext, input logic [7:0] code);
        logic [6:0] r;
        r = 7'd0;
        if (!ext) begin
            case (code)
                8'h12: r = {1'b1, 6'd0};  8'h1A: r = {1'b1, 6'd1};
                8'h22: r = {1'b1, 6'd2};  8'h21: r = {1'b1, 6'd3};
                8'h2A: r = {1'b1, 6'd4};  8'h1C: r = {1'b1, 6'd5};
                8'h1B: r = {1'b1, 6'd6};  8'h23: r = {1'b1, 6'd7};
                8'h2B: r = {1'b1, 6'd8};  8'h34: r = {1'b1, 6'd9};
                8'h15: r = {1'b1, 6'd10}; 8'h1D: r = {1'b1, 6'd11};
                8'h24: r = {1'b1, 6'd12}; 8'h2D: r = {1'b1, 6'd13};
                8'h2C: r = {1'b1, 6'd14}; 8'h16: r = {1'b1, 6'd15};
                8'h1E: r = {1'b1, 6'd16}; 8'h26: r = {1'b1, 6'd17};
                8'h25: r = {1'b1, 6'd18}; 8'h2E: r = {1'b1, 6'd19};
                8'h45: r = {1'b1, 6'd20}; 8'h46: r = {1'b1, 6'd21};
                8'h3E: r = {1'b1, 6'd22}; 8'h3D: r = {1'b1, 6'd23};
                8'h36: r = {1'b1, 6'd24}; 8'h4D: r = {1'b1, 6'd25};
                8'h44: r = {1'b1, 6'd26}; 8'h43: r = {1'b1, 6'd27};
                8'h3C: r = {1'b1, 6'd28}; 8'h35: r = {1'b1, 6'd29};
                8'h5A: r = {1'b1, 6'd30}; 8'h4B: r = {1'b1, 6'd31};
                8'h42: r = {1'b1, 6'd32}; 8'h3B: r = {1'b1, 6'd33};
                8'h33: r = {1'b1, 6'd34}; 8'h29: r = {1'b1, 6'd35};
                8'h59: r = {1'b1, 6'd36}; 8'h3A: r = {1'b1, 6'd37};
                8'h31: r = {1'b1, 6'd38}; 8'h32: r = {1'b1, 6'd39};
                8'h14: r = {1'b1, 6'(SRC_LCTRL)};
                8'h66: r = {1'b1, 6'(SRC_BKSP)};
                8'h11: r = {1'b1, 6'(SRC_LALT)};
                default: r = 7'd0;
            endcase
        end else begin
            case (code)
                8'h74: r = {1'b1, 6'(SRC_RIGHT)};
                8'h6B: r = {1'b1, 6'(SRC_LEFT)};
                8'h72: r = {1'b1, 6'(SRC_DOWN)};
                8'h75: r = {1'b1, 6'(SRC_UP)};
                8'h11: r = {1'b1, 6'(SRC_RALT)};
                8'h14: r = {1'b1, 6'(SRC_RCTRL)};
                8'h71: r = {1'b1, 6'(SRC_DEL)};
                default: r = 7'd0;
            endcase
        end
        return r;
    endfunction

    logic            ext_q, brk_q, res_k_q, frame_err_q;
    logic [NSRC-1:0] held_q, held_d;
    logic [6:0]      w_map;
    logic            w_prefix, w_res_fire;

    assign w_map      = map_code(ext_q, shift_q);
    assign w_prefix   = (shift_q == 8'hE0) || (shift_q == 8'hF0);
    // Delete make with Ctrl and Alt down; a held Delete (typematic) cannot refire.
    assign w_res_fire = w_good && !w_prefix && ext_q && !brk_q && (shift_q == 8'h71)
                        && !held_q[SRC_DEL]
                        && (held_q[SRC_LCTRL] || held_q[SRC_RCTRL])
                        && (held_q[SRC_LALT]  || held_q[SRC_RALT]);

    always_comb begin
        held_d = held_q;
        if (w_good && !w_prefix && w_map[6]) begin
            for (int i = 0; i < NSRC; i++) begin
                if (w_map[5:0] == 6'(i)) held_d[i] = ~brk_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            held_q      <= '0;
            res_k_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            held_q      <= held_d;
            res_k_q     <= w_res_fire;
            frame_err_q <= w_bad;
            if (w_good) begin
                if (shift_q == 8'hE0) begin
                    ext_q <= 1'b1;
                end else if (shift_q == 8'hF0) begin
                    brk_q <= 1'b1;
                end else begin
                    ext_q <= 1'b0;
                    brk_q <= 1'b0;
                end
            end
        end
    end

    // ---------------------------------------------------------------- matrix
    logic [39:0] w_mtx;

    always_comb begin
        w_mtx     = held_q[39:0];
        w_mtx[36] = w_mtx[36] | held_q[SRC_LCTRL];   // SS
        w_mtx[0]  = w_mtx[0]  | held_q[SRC_BKSP];    // CS
        w_mtx[20] = w_mtx[20] | held_q[SRC_BKSP];    // 0
`ifndef ZX_KEMPSTON_EN
        w_mtx[0]  = w_mtx[0]  | (|held_q[SRC_UP:SRC_RIGHT]);
        w_mtx[22] = w_mtx[22] | held_q[SRC_RIGHT];   // 8
        w_mtx[19] = w_mtx[19] | held_q[SRC_LEFT];    // 5
        w_mtx[24] = w_mtx[24] | held_q[SRC_DOWN];    // 6
        w_mtx[23] = w_mtx[23] | held_q[SRC_UP];      // 7
`endif
    end

    always_comb begin
        zx_kb_out = 5'b11111;
        for (int r = 0; r < 8; r++) begin
            if (!zx_kb_scan[r]) zx_kb_out = zx_kb_out & ~w_mtx[r*5 +: 5];
        end
    end

`ifdef ZX_KEMPSTON_EN
    assign k_joy = held_q[SRC_RALT:SRC_RIGHT];
`else
    assign k_joy = 5'd0;
`endif

    assign res_k     = res_k_q;
    assign frame_err = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_zx_ps2_matrix.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_zx_ps2_matrix                                             |
// | Description : Directed table-driven bench for zx_ps2_matrix.               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_zx_ps2_matrix;
    localparam int HP = 20;   // PS/2 half bit period in clk cycles

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] zx_kb_scan = 8'hFF;
    logic [4:0] zx_kb_out, k_joy;
    logic       res_k, frame_err;

    zx_ps2_matrix dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .zx_kb_scan (zx_kb_scan),
        .zx_kb_out  (zx_kb_out),
        .k_joy      (k_joy),
        .res_k      (res_k),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int fe_cnt   = 0;
    int rk_cnt   = 0;

    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (res_k)     rk_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        tick(1);
        ps2_data = b;
        tick(HP);
        ps2_clk = 1'b0;
        tick(HP);
        ps2_clk = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par);
        logic p;
        p = ~(^b) ^ bad_par;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(p);
        send_bit(1'b1);
        tick(HP);
    endtask

    task automatic send_key(input logic ext, input logic brk, input logic [7:0] code);
        if (ext) send_byte(8'hE0, 1'b0);
        if (brk) send_byte(8'hF0, 1'b0);
        send_byte(code, 1'b0);
    endtask

    typedef struct packed {
        logic       snd;
        logic       ext;
        logic       brk;
        logic [7:0] code;
        logic [7:0] scan;
        logic [4:0] kb;
        logic [4:0] joy;
    } vec_t;

    vec_t vt[$];

    initial begin
        int fe0, rk0;
        // Matrix and plain-key vectors (state is cumulative).
        vt.push_back('{1'b1,1'b0,1'b0,8'h1C,8'hFD,5'b11110,5'b0});
        vt.push_back('{1'b0,1'b0,1'b0,8'h00,8'hFE,5'b11111,5'b0});
        vt.push_back('{1'b1,1'b0,1'b1,8'h1C,8'hFD,5'b11111,5'b0});
        vt.push_back('{1'b1,1'b0,1'b0,8'h1C,8'hFD,5'b11110,5'b0});
        vt.push_back('{1'b1,1'b0,1'b1,8'h1C,8'hFD,5'b11111,5'b0});
        vt.push_back('{1'b1,1'b0,1'b0,8'h12,8'hFE,5'b11110,5'b0});
        vt.push_back('{1'b1,1'b0,1'b0,8'h66,8'hEF,5'b11110,5'b0});
        vt.push_back('{1'b1,1'b0,1'b1,8'h12,8'hFE,5'b11110,5'b0});
        vt.push_back('{1'b1,1'b0,1'b1,8'h66,8'hEE,5'b11111,5'b0});
        vt.push_back('{1'b1,1'b0,1'b0,8'h59,8'h7F,5'b11101,5'b0});
        vt.push_back('{1'b1,1'b0,1'b0,8'h14,8'h7F,5'b11101,5'b0});
        vt.push_back('{1'b1,1'b0,1'b1,8'h59,8'h7F,5'b11101,5'b0});
        vt.push_back('{1'b1,1'b0,1'b1,8'h14,8'h7F,5'b11111,5'b0});
        vt.push_back('{1'b1,1'b0,1'b0,8'h3A,8'h7F,5'b11011,5'b0});
        vt.push_back('{1'b1,1'b0,1'b0,8'h29,8'h7F,5'b11010,5'b0});
        vt.push_back('{1'b1,1'b0,1'b0,8'h15,8'h7B,5'b11010,5'b0});
        vt.push_back('{1'b0,1'b0,1'b0,8'h00,8'hFB,5'b11110,5'b0});
        vt.push_back('{1'b0,1'b0,1'b0,8'h00,8'hFF,5'b11111,5'b0});
        vt.push_back('{1'b1,1'b0,1'b1,8'h3A,8'h7F,5'b11110,5'b0});
        vt.push_back('{1'b1,1'b0,1'b1,8'h29,8'h7F,5'b11111,5'b0});
        vt.push_back('{1'b1,1'b0,1'b1,8'h15,8'hFB,5'b11111,5'b0});
        vt.push_back('{1'b1,1'b0,1'b0,8'h45,8'hEF,5'b11110,5'b0});
        vt.push_back('{1'b1,1'b0,1'b0,8'h5A,8'hBF,5'b11110,5'b0});
        vt.push_back('{1'b1,1'b0,1'b1,8'h45,8'hEF,5'b11111,5'b0});
        vt.push_back('{1'b1,1'b0,1'b1,8'h5A,8'hBF,5'b11111,5'b0});
        vt.push_back('{1'b1,1'b0,1'b0,8'h05,8'h00,5'b11111,5'b0});
        // Arrow / RAlt vectors.
`ifdef ZX_KEMPSTON_EN
        vt.push_back('{1'b1,1'b1,1'b0,8'h6B,8'hFE,5'b11111,5'b00010});
        vt.push_back('{1'b0,1'b0,1'b0,8'h00,8'hF7,5'b11111,5'b00010});
        vt.push_back('{1'b1,1'b1,1'b0,8'h74,8'hEF,5'b11111,5'b00011});
        vt.push_back('{1'b1,1'b1,1'b0,8'h11,8'hEE,5'b11111,5'b10011});
        vt.push_back('{1'b1,1'b1,1'b1,8'h6B,8'hF7,5'b11111,5'b10001});
        vt.push_back('{1'b0,1'b0,1'b0,8'h00,8'hFE,5'b11111,5'b10001});
        vt.push_back('{1'b1,1'b1,1'b1,8'h74,8'hEE,5'b11111,5'b10000});
`else
        vt.push_back('{1'b1,1'b1,1'b0,8'h6B,8'hFE,5'b11110,5'b0});
        vt.push_back('{1'b0,1'b0,1'b0,8'h00,8'hF7,5'b01111,5'b0});
        vt.push_back('{1'b1,1'b1,1'b0,8'h74,8'hEF,5'b11011,5'b0});
        vt.push_back('{1'b1,1'b1,1'b0,8'h11,8'hEE,5'b11010,5'b0});
        vt.push_back('{1'b1,1'b1,1'b1,8'h6B,8'hF7,5'b11111,5'b0});
        vt.push_back('{1'b0,1'b0,1'b0,8'h00,8'hFE,5'b11110,5'b0});
        vt.push_back('{1'b1,1'b1,1'b1,8'h74,8'hEE,5'b11111,5'b0});
`endif
        vt.push_back('{1'b1,1'b1,1'b1,8'h11,8'h00,5'b11111,5'b0});

        // Reset state.
        zx_kb_scan = 8'h00;
        tick(3);
        @(negedge clk);
        chk("reset kb_out", 32'(zx_kb_out), 32'h1F);
        chk("reset k_joy", 32'(k_joy), 32'h0);
        chk("reset res_k", 32'(res_k), 32'h0);
        chk("reset frame_err", 32'(frame_err), 32'h0);
        reset = 1'b1;
        tick(5);

        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].snd) send_key(vt[i].ext, vt[i].brk, vt[i].code);
            zx_kb_scan = vt[i].scan;
            @(negedge clk);
            chk($sformatf("vec%0d kb_out", i), 32'(zx_kb_out), 32'(vt[i].kb));
            chk($sformatf("vec%0d k_joy", i), 32'(k_joy), 32'(vt[i].joy));
        end
        chk("table frame_err count", 32'(fe_cnt), 32'd0);
        chk("table res_k count", 32'(rk_cnt), 32'd0);

        // Bad parity on 0x29: one frame_err pulse, matrix untouched.
        fe0 = fe_cnt;
        send_byte(8'h29, 1'b1);
        zx_kb_scan = 8'h7F;
        @(negedge clk);
        chk("bad parity frame_err pulses", 32'(fe_cnt - fe0), 32'd1);
        chk("bad parity kb_out", 32'(zx_kb_out), 32'h1F);

        // Partial frame abandoned after the idle timeout.
        fe0 = fe_cnt;
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        tick(28000);
        send_byte(8'h29, 1'b0);
        zx_kb_scan = 8'h7F;
        @(negedge clk);
        chk("timeout then space kb_out", 32'(zx_kb_out), 32'h1E);
        chk("timeout no frame_err", 32'(fe_cnt - fe0), 32'd0);
        send_key(1'b0, 1'b1, 8'h29);
        @(negedge clk);
        chk("space released kb_out", 32'(zx_kb_out), 32'h1F);

        // Ctrl+Alt+Del, typematic repeat, re-arm after release.
        rk0 = rk_cnt;
        send_key(1'b0, 1'b0, 8'h71 ^ 8'h71 ^ 8'h14);
        send_key(1'b0, 1'b0, 8'h11);
        send_key(1'b1, 1'b0, 8'h71);
        chk("ctrl alt del pulse", 32'(rk_cnt - rk0), 32'd1);
        send_key(1'b1, 1'b0, 8'h71);
        chk("del repeat no pulse", 32'(rk_cnt - rk0), 32'd1);
        send_key(1'b1, 1'b1, 8'h71);
        send_key(1'b1, 1'b0, 8'h71);
        chk("del re-armed pulse", 32'(rk_cnt - rk0), 32'd2);
        send_key(1'b1, 1'b1, 8'h71);
        send_key(1'b0, 1'b1, 8'h11);
        send_key(1'b1, 1'b0, 8'h71);
        chk("no alt no pulse", 32'(rk_cnt - rk0), 32'd2);
        send_key(1'b1, 1'b1, 8'h71);
        send_key(1'b0, 1'b1, 8'h14);

        // Reset in the middle of a frame with keys held.
        send_key(1'b0, 1'b0, 8'h12);
        send_key(1'b1, 1'b0, 8'h6B);
        zx_kb_scan = 8'hFE;
        @(negedge clk);
        chk("pre-reset kb_out", 32'(zx_kb_out), 32'h1E);
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        #3;
        reset = 1'b0;
        #1;
        chk("mid-frame reset kb_out", 32'(zx_kb_out), 32'h1F);
        chk("mid-frame reset k_joy", 32'(k_joy), 32'h0);
        chk("mid-frame reset res_k", 32'(res_k), 32'h0);
        chk("mid-frame reset frame_err", 32'(frame_err), 32'h0);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        tick(4);
        reset = 1'b1;
        tick(4);
        fe0 = fe_cnt;
        send_byte(8'h1C, 1'b0);
        zx_kb_scan = 8'hFD;
        @(negedge clk);
        chk("after reset A kb_out", 32'(zx_kb_out), 32'h1E);
        chk("after reset no frame_err", 32'(fe_cnt - fe0), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
